// File: rtl/fifo_pkg.sv
// Shared definitions for the single-port FIFO controller:
// arbitration priority encoding and pointer/count widths.
package fifo_pkg;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/RAM_1Port.sv
// Single-port synchronous RAM: one write or one read per cycle.
// Read data appears one cycle after the read enable; contents are never reset.
module RAM_1Port
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_We,
  input  logic                    i_Re,
  input  logic [ptr_w(DEPTH)-1:0] i_Addr,
  input  logic [WIDTH-1:0]        i_Wr_Data,
  output logic [WIDTH-1:0]        o_Rd_Data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array and registered read port share the single address
  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      mem_q[i_Addr] <= i_Wr_Data;
    end else if (i_Re) begin
      rd_data_q <= mem_q[i_Addr];
    end
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/fifo_1port_ctrl.sv
// FIFO controller over a single-port RAM with round-robin
// arbitration between writes and reads under contention.
module fifo_1port_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Wr_DV,
  input  logic [WIDTH-1:0]        i_Wr_Data,
  output logic                    o_Wr_Rdy,
  input  logic                    i_Rd_En,
  output logic                    o_Rd_Rdy,
  output logic                    o_Rd_DV,
  output logic [WIDTH-1:0]        o_Rd_Data,
  output logic [cnt_w(DEPTH)-1:0] o_Count,
  output logic                    o_Full,
  output logic                    o_Empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  prio_e         prio_q, prio_d;
  logic          rd_dv_q, rd_dv_d;

  logic             full, empty;
  logic             wr_cont, rd_cont;
  logic             wr_rdy, rd_rdy;
  logic             wr_acc, rd_acc;
  logic [PW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata;

  // Arbitrate the single RAM port; priority only matters when both contend
  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    wr_cont = i_Wr_DV && !full;
    rd_cont = i_Rd_En && !empty;
    wr_rdy  = !full && !(rd_cont && prio_q == PRIO_READ);
    rd_rdy  = !empty && !(wr_cont && prio_q == PRIO_WRITE);
    wr_acc  = i_Wr_DV && wr_rdy;
    rd_acc  = i_Rd_En && rd_rdy;
    ram_addr = wr_acc ? wr_ptr_q : rd_ptr_q;
  end

  // Next-state for pointers, occupancy, priority and read-valid pipeline
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    rd_dv_d  = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
    if (wr_cont && rd_cont) begin
      prio_d = wr_acc ? PRIO_READ : PRIO_WRITE;
    end
  end

  // Controller state with asynchronous reset
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= PRIO_WRITE;
      rd_dv_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
      rd_dv_q  <= rd_dv_d;
    end
  end

  RAM_1Port #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .i_Clk    (i_Clk),
    .i_We     (wr_acc),
    .i_Re     (rd_acc),
    .i_Addr   (ram_addr),
    .i_Wr_Data(i_Wr_Data),
    .o_Rd_Data(ram_rdata)
  );

  assign o_Wr_Rdy  = wr_rdy;
  assign o_Rd_Rdy  = rd_rdy;
  assign o_Rd_DV   = rd_dv_q;
  assign o_Rd_Data = rd_dv_q ? ram_rdata : '0;
  assign o_Count   = count_q;
  assign o_Full    = full;
  assign o_Empty   = empty;

endmodule
